seq_tx: RTL

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx_pkg.sv | 25 ++
 rtl/seq_tx_shifter.sv | 33 +++
 rtl/seq_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the seq_tx serializer: FSM states, preamble
// pattern and a sizing helper for the bit counter.
package seq_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_t;

  localparam logic [2:0]  PREAMBLE     = 3'b101;
  localparam int unsigned PREAMBLE_LEN = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable MSB-first shift register; parity of the captured word is held
// alongside so it stays valid after the data has been shifted out.
module seq_tx_shifter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_msb,
  output logic              o_parity
);

  logic [DATA_W-1:0] r_sh;
  logic              r_par;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh  <= '0;
      r_par <= 1'b0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_par <= ^i_data;
    end else if (i_shift) begin
      r_sh  <= r_sh << 1;
    end
  end

  assign o_msb    = r_sh[DATA_W-1];
  assign o_parity = r_par;

endmodule

// File: rtl/seq_tx.sv
// Frame serializer: preamble 101, DATA_W bits MSB first, optional even parity,
// then GAP_LEN idle cycles. Moore FSM; all outputs decode registered state.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned CNT_MAX = max3(DATA_W, GAP_LEN, PREAMBLE_LEN);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  // Counter holds cycles remaining in the current state; reloaded on entry.
  localparam logic [CW-1:0] LD_PRE  = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] LD_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_load;
  logic          w_shift;
  logic          w_msb;
  logic          w_parity;

  seq_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_load  (w_load),
    .i_data  (in_data),
    .i_shift (w_shift),
    .o_msb   (w_msb),
    .o_parity(w_parity)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    in_ready   = 1'b0;
    out        = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_load     = 1'b1;
          w_next     = ST_PRE;
          w_cnt_next = LD_PRE;
        end
      end
      ST_PRE: begin
        out_valid = 1'b1;
        out       = PREAMBLE[r_cnt[1:0]];
        if (r_cnt == '0) begin
          w_next     = ST_DATA;
          w_cnt_next = LD_DATA;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DATA: begin
        out_valid = 1'b1;
        out       = w_msb;
        w_shift   = 1'b1;
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (PARITY_EN != 0) begin
          w_next     = ST_PAR;
          w_cnt_next = '0;
        end else if (GAP_LEN != 0) begin
          w_next     = ST_GAP;
          w_cnt_next = LD_GAP;
        end else begin
          w_next     = ST_IDLE;
          w_cnt_next = '0;
        end
      end
      ST_PAR: begin
        out_valid = 1'b1;
        out       = w_parity;
        if (GAP_LEN != 0) begin
          w_next     = ST_GAP;
          w_cnt_next = LD_GAP;
        end else begin
          w_next     = ST_IDLE;
          w_cnt_next = '0;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_next     = ST_IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_next     = ST_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

endmodule
